// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, hold-until-release
// semantics and an optional hold timeout that preempts a long-running winner.
module rr_arbiter8 #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         timeout
);

  localparam int IW = $clog2(N);
  // Keep at least one counter bit so a disabled timeout still elaborates cleanly.
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic [IW-1:0]   scan_win;
  logic            hold_expired;

  // Scan from lowest to highest priority so the nearest set bit after ptr wins last.
  always_comb begin
    logic [IW-1:0] idx;
    scan_win = '0;
    idx      = '0;
    for (int k = N; k >= 1; k--) begin
      idx = ptr_q + IW'(k);
      if (req[idx]) scan_win = idx;
    end
  end

  assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d   = scan_win;
          grant_d = N'(1) << scan_win;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Release takes precedence over a timeout landing on the same edge.
        if (!req[win_q]) begin
          grant_d = '0;
          ptr_d   = win_q;
          state_d = IDLE;
        end else if (hold_expired) begin
          grant_d   = '0;
          ptr_d     = win_q;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(N - 1);
      win_q     <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = |grant_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios followed by random request traffic,
// all compared against an owner/pointer reference model.
module tb_rr_arbiter8;
  localparam int MH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 when none), cycles it has been visible,
  // last released index, and whether the last edge ended a grant by timeout.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 7;
  bit m_tmo   = 1'b0;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_grant();
    return (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
  endfunction

  function automatic int enc(input logic [7:0] g);
    for (int i = 0; i < 8; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 7;
    m_tmo   = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          int i;
          i = (m_ptr + k) % 8;
          if (r[i]) begin
            m_owner = i;
            m_held  = 1;
            break;
          end
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = m_owner;
      m_owner = -1;
    end else if (MH != 0 && m_held == MH) begin
      m_ptr   = m_owner;
      m_owner = -1;
      m_tmo   = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] g;
    g = grant;
    chk("grant", grant, m_grant());
    chk("busy", {7'b0, busy}, {7'b0, (m_owner >= 0)});
    chk("timeout", {7'b0, timeout}, {7'b0, m_tmo});
    chk("onehot0", {7'b0, $onehot0(g)}, 8'h01);
  endtask

  // One clock: drive req, let the edge happen, advance the model, sample.
  task automatic cycle(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_grant", grant, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    int         gcnt;
    int         ord;

    // Reset held with no requests
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("t1_grant", grant, 8'h00);
      chk("t1_busy", {7'b0, busy}, 8'h00);
      chk("t1_timeout", {7'b0, timeout}, 8'h00);
    end
    rst_n = 1'b1;
    model_reset();

    // Single requester for exactly MAX_HOLD cycles, then released
    repeat (4) begin
      cycle(8'h08);
      chk("t2_grant", grant, 8'h08);
      chk("t2_code", 8'(enc(grant)), 8'd3);
    end
    cycle(8'h00);
    chk("t2_release", grant, 8'h00);
    chk("t2_no_tmo", {7'b0, timeout}, 8'h00);

    // All request; each drops two cycles after being granted
    do_reset();
    r    = 8'hFF;
    gcnt = 0;
    ord  = 0;
    for (int c = 0; c < 40; c++) begin
      if (r == 8'h00 && m_owner < 0) break;
      cycle(r);
      if (m_owner >= 0) begin
        gcnt++;
        if (gcnt == 1) begin
          chk("t3_order", grant, 8'h01 << ord);
          ord++;
        end
        if (gcnt == 2) begin
          r[m_owner] = 1'b0;
          gcnt = 0;
        end
      end
    end
    chk("t3_count", 8'(ord), 8'd8);

    // Pointer wrap past index 7
    do_reset();
    cycle(8'h40);
    chk("t4_g6", grant, 8'h40);
    cycle(8'h00);
    cycle(8'h41);
    chk("t4_wrap", grant, 8'h01);

    // Timeout preemption and re-entry at lowest priority
    do_reset();
    cycle(8'h04);
    chk("t5_first", grant, 8'h04);
    repeat (3) begin
      cycle(8'h24);
      chk("t5_hold", grant, 8'h04);
    end
    cycle(8'h24);
    chk("t5_tmo_pulse", {7'b0, timeout}, 8'h01);
    chk("t5_tmo_grant", grant, 8'h00);
    cycle(8'h24);
    chk("t5_next", grant, 8'h20);
    chk("t5_tmo_clear", {7'b0, timeout}, 8'h00);
    cycle(8'h24);
    cycle(8'h04);
    chk("t5_gap", grant, 8'h00);
    cycle(8'h04);
    chk("t5_back", grant, 8'h04);

    // Asynchronous reset mid-grant
    do_reset();
    cycle(8'h10);
    chk("t6_g4", grant, 8'h10);
    cycle(8'h11);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_grant", grant, 8'h00);
    chk("t6_async_busy", {7'b0, busy}, 8'h00);
    #1;
    rst_n = 1'b1;
    cycle(8'h11);
    chk("t6_after", grant, 8'h01);

    // Random traffic against the model, with occasional async resets
    do_reset();
    r = 8'h00;
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      else if ($urandom_range(0, 3) == 0) r = r & ~(8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rnd_async", grant, 8'h00);
        #1;
        rst_n = 1'b1;
      end
      cycle(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
